// File: rtl/cr_cddip_sa_sched.sv
// cr_cddip_sa_sched: sequences snapshot/clear of the stats aggregator and streams every snapshot counter out as a 64-bit word
module cr_cddip_sa_sched #(
  parameter int NUM_CTR    = 64,
  parameter int CTR_W      = 50,
  parameter int TIMER_W    = 32,
  parameter int SETTLE_CYC = 4,
  parameter int SNAP_HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_enable,
  input  logic [TIMER_W-1:0] cfg_period,
  input  logic               sw_snap_req,
  input  logic               sw_clear_req,
  output logic               regs_sa_snap,
  output logic               regs_sa_clear_live,
  output logic [5:0]         sa_snap_sel,
  input  logic [CTR_W-1:0]   sa_snap_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_data,
  output logic               out_last,
  output logic               busy,
  output logic [7:0]         dump_seq,
  output logic [7:0]         overrun_cnt
);
  typedef enum logic [2:0] {IDLE, CLR, SNAP, SETTLE, RD, CAP, SEND} state_t;
  localparam logic [7:0] HOLD_LAST   = 8'(SNAP_HOLD - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [5:0] LAST_IDX    = 6'(NUM_CTR - 1);
  state_t state, state_n;
  logic [TIMER_W-1:0] timer;
  logic [7:0] cnt, cnt_n;
  logic [5:0] idx, idx_n;
  logic snap_pend, clear_pend;
  logic run, trig, hs, clr_go, snap_go;
  assign run     = cfg_enable && cfg_period != '0;
  assign trig    = (run && timer == TIMER_W'(1)) || sw_snap_req;
  assign hs      = out_valid && out_ready;
  assign clr_go  = state == IDLE && clear_pend;
  assign snap_go = state == IDLE && !clear_pend && snap_pend;
  assign busy               = state != IDLE;
  assign regs_sa_snap       = state == SNAP;
  assign regs_sa_clear_live = state == CLR;
  // next-state, hold/settle counter and readout index
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    idx_n   = idx;
    case (state)
      IDLE:    state_n = clear_pend ? CLR : snap_pend ? SNAP : IDLE;
      CLR:     begin
        state_n = cnt == HOLD_LAST ? IDLE : CLR;
        cnt_n   = cnt == HOLD_LAST ? '0 : cnt + 8'd1;
      end
      SNAP:    begin
        state_n = cnt == HOLD_LAST ? SETTLE : SNAP;
        cnt_n   = cnt == HOLD_LAST ? '0 : cnt + 8'd1;
      end
      SETTLE:  begin
        state_n = cnt == SETTLE_LAST ? RD : SETTLE;
        cnt_n   = cnt == SETTLE_LAST ? '0 : cnt + 8'd1;
        idx_n   = '0;
      end
      RD:      state_n = CAP;
      CAP:     state_n = SEND;
      SEND:    begin
        state_n = !hs ? SEND : idx == LAST_IDX ? IDLE : RD;
        idx_n   = hs && idx != LAST_IDX ? idx + 6'd1 : idx;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register, period timer, request merging and output word register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= cfg_period;
      cnt         <= '0;
      idx         <= '0;
      snap_pend   <= 1'b0;
      clear_pend  <= 1'b0;
      sa_snap_sel <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      dump_seq    <= '0;
      overrun_cnt <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      timer      <= !run ? timer : timer <= TIMER_W'(1) ? cfg_period : timer - TIMER_W'(1);
      snap_pend  <= snap_go ? 1'b0 : snap_pend | trig;
      clear_pend <= clr_go ? 1'b0 : clear_pend | sw_clear_req;
      dump_seq   <= snap_go ? dump_seq + 8'd1 : dump_seq;
      if (trig && (snap_pend || state != IDLE) && overrun_cnt != 8'hff)
        overrun_cnt <= overrun_cnt + 8'd1;
      if (state_n == RD)
        sa_snap_sel <= idx_n;
      if (state == CAP) begin
        out_data  <= {dump_seq, idx, sa_snap_data};
        out_valid <= 1'b1;
        out_last  <= idx == LAST_IDX;
      end else if (hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cr_cddip_sa_sched.sv
// tb_cr_cddip_sa_sched: directed self-checking bench for the snapshot dump scheduler
module tb_cr_cddip_sa_sched;
  localparam int NUM_CTR = 64;
  localparam int CTR_W   = 50;
  logic clk = 1'b0, rst = 1'b1, cfg_enable = 1'b0, sw_snap_req = 1'b0, sw_clear_req = 1'b0, out_ready = 1'b0;
  logic [31:0] cfg_period = '0;
  logic regs_sa_snap, regs_sa_clear_live, out_valid, out_last, busy;
  logic [5:0] sa_snap_sel;
  logic [CTR_W-1:0] sa_snap_data;
  logic [63:0] out_data;
  logic [7:0] dump_seq, overrun_cnt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign sa_snap_data = CTR_W'(1000) + CTR_W'(sa_snap_sel);
  cr_cddip_sa_sched dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_period(cfg_period),
    .sw_snap_req(sw_snap_req), .sw_clear_req(sw_clear_req),
    .regs_sa_snap(regs_sa_snap), .regs_sa_clear_live(regs_sa_clear_live),
    .sa_snap_sel(sa_snap_sel), .sa_snap_data(sa_snap_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .dump_seq(dump_seq), .overrun_cnt(overrun_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    sw_snap_req = 1'b0;
    sw_clear_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic pulse_snap();
    @(negedge clk);
    sw_snap_req = 1'b1;
    @(negedge clk);
    sw_snap_req = 1'b0;
  endtask
  task automatic dump(input logic [7:0] seq, input int pct, input int budget, output int start, output int dur);
    int n = 0, snap_hi = 0, t = 0;
    logic held = 1'b0;
    logic [63:0] hd = '0;
    start = -1;
    dur = -1;
    while (t < budget && dur < 0) begin
      @(negedge clk);
      t++;
      out_ready = $urandom_range(99) < 32'(pct);
      #1;
      if (regs_sa_snap) begin
        snap_hi++;
        if (start < 0) start = t;
      end
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", out_data, hd);
      end
      held = out_valid && !out_ready;
      hd = out_data;
      if (out_valid && out_ready) begin
        chk("word", out_data, {seq, 6'(n), CTR_W'(1000 + n)});
        chk("last", 64'(out_last), 64'(n == NUM_CTR - 1));
        n++;
      end
      if (start >= 0 && !busy) dur = t - start;
    end
    chk("word_count", 64'(n), 64'(NUM_CTR));
    chk("snap_hold", 64'(snap_hi), 64'd2);
    chk("dump_done", 64'(dur >= 0), 64'd1);
  endtask
  initial begin
    int st, du, t, nr, r0, r1, r2;
    logic prev, found;
    logic [7:0] ch, sh;
    // 1: reset state, single software snapshot, full dump timing
    out_ready = 1'b1;
    do_reset();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_snap", 64'(regs_sa_snap), 64'd0);
    chk("rst_clear", 64'(regs_sa_clear_live), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_sel", 64'(sa_snap_sel), 64'd0);
    chk("rst_seq", 64'(dump_seq), 64'd0);
    chk("rst_ovr", 64'(overrun_cnt), 64'd0);
    pulse_snap();
    dump(8'd1, 100, 400, st, du);
    chk("t1_start", 64'(st), 64'd1);
    chk("t1_duration", 64'(du), 64'd198);
    chk("t1_seq", 64'(dump_seq), 64'd1);
    chk("t1_ovr", 64'(overrun_cnt), 64'd0);
    // 2: periodic trigger every 300 cycles
    cfg_period = 32'd300;
    cfg_enable = 1'b1;
    out_ready = 1'b1;
    do_reset();
    nr = 0; r0 = 0; r1 = 0; r2 = 0; prev = 1'b0;
    for (t = 1; t <= 1000; t++) begin
      @(negedge clk);
      if (regs_sa_snap && !prev) begin
        if (nr == 0) r0 = t;
        if (nr == 1) r1 = t;
        if (nr == 2) r2 = t;
        nr++;
      end
      prev = regs_sa_snap;
    end
    chk("t2_snaps", 64'(nr), 64'd3);
    chk("t2_first", 64'(r0), 64'd301);
    chk("t2_period1", 64'(r1 - r0), 64'd300);
    chk("t2_period2", 64'(r2 - r1), 64'd300);
    chk("t2_ovr", 64'(overrun_cnt), 64'd0);
    chk("t2_seq", 64'(dump_seq), 64'd3);
    // 3: period shorter than a dump, back-to-back dumps with overruns
    cfg_period = 32'd100;
    do_reset();
    dump(8'd1, 100, 400, st, du);
    chk("t3_start1", 64'(st), 64'd101);
    dump(8'd2, 100, 400, st, du);
    chk("t3_start2", 64'(st), 64'd1);
    dump(8'd3, 100, 400, st, du);
    chk("t3_start3", 64'(st), 64'd1);
    chk("t3_seq", 64'(dump_seq), 64'd3);
    chk("t3_ovr_nonzero", 64'(overrun_cnt != 8'd0), 64'd1);
    // 4: random backpressure
    cfg_enable = 1'b0;
    cfg_period = 32'd0;
    do_reset();
    pulse_snap();
    dump(8'd1, 30, 4000, st, du);
    chk("t4_ovr", 64'(overrun_cnt), 64'd0);
    // 5: simultaneous clear and snap requests
    do_reset();
    @(negedge clk);
    sw_clear_req = 1'b1;
    sw_snap_req = 1'b1;
    @(negedge clk);
    sw_clear_req = 1'b0;
    sw_snap_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ch[k] = regs_sa_clear_live;
      sh[k] = regs_sa_snap;
    end
    chk("t5_clear_seq", 64'(ch), 64'h03);
    chk("t5_snap_seq", 64'(sh), 64'h18);
    chk("t5_seq", 64'(dump_seq), 64'd1);
    chk("t5_ovr", 64'(overrun_cnt), 64'd0);
    // 6: reset while holding word 20, then a clean restart
    do_reset();
    out_ready = 1'b1;
    pulse_snap();
    found = 1'b0;
    for (t = 0; t < 300 && !found; t++) begin
      @(negedge clk);
      if (out_valid && out_data[55:50] == 6'd20) begin
        out_ready = 1'b0;
        rst = 1'b1;
        found = 1'b1;
      end
    end
    chk("t6_reached_idx20", 64'(found), 64'd1);
    @(negedge clk);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_snap", 64'(regs_sa_snap), 64'd0);
    chk("t6_clear", 64'(regs_sa_clear_live), 64'd0);
    chk("t6_seq_rst", 64'(dump_seq), 64'd0);
    rst = 1'b0;
    pulse_snap();
    dump(8'd1, 100, 400, st, du);
    chk("t6_duration", 64'(du), 64'd198);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
